// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Drains a requested number of words from an attached first-word-fall-through
// FIFO and presents them on a valid/ready output stream through a single
// register stage. The final word of each burst is flagged with m_last_o.
//
// Ports
//   clk            single clock, all state updates on posedge
//   rst            synchronous reset, active-low
//   clear_i        synchronous soft clear, active-high (abandons any burst)
//   burst_valid_i  burst request valid
//   burst_len_i    number of words to drain for the request
//   burst_ready_o  block can accept a burst request (IDLE only)
//   fifo_empty_i   FIFO empty flag
//   fifo_data_i    FIFO head word, valid whenever fifo_empty_i=0
//   fifo_read_o    FIFO pop strobe, head consumed on the same edge
//   m_valid_o      output word valid
//   m_data_o       output word
//   m_last_o       final word of the burst
//   m_ready_i      downstream accepts the word
//   busy_o         burst in progress
//   remain_o       words still to be popped in the current burst
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | waiting for a burst request; burst_ready_o=1
// RUN   | popping words from the FIFO until remain reaches 0
// DRAIN | all words popped; waiting for the last word to be accepted
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear_i,
    input  logic             burst_valid_i,
    input  logic [LEN_W-1:0] burst_len_i,
    output logic             burst_ready_o,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_data_i,
    output logic             fifo_read_o,
    output logic             m_valid_o,
    output logic [WIDTH-1:0] m_data_o,
    output logic             m_last_o,
    input  logic             m_ready_i,
    output logic             busy_o,
    output logic [LEN_W-1:0] remain_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [LEN_W-1:0] remain_q, remain_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             load;
    logic             handshake;

    assign handshake = valid_q && m_ready_i;

    // The pop is suppressed during reset and clear so that neither one
    // consumes a FIFO word that the abandoned burst would never deliver.
    assign load = rst && !clear_i
                  && (state_q == RUN)
                  && (remain_q != '0)
                  && !fifo_empty_i
                  && (!valid_q || m_ready_i);

    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        data_d   = data_q;
        valid_d  = valid_q;
        last_d   = last_q;

        if (clear_i) begin
            state_d  = IDLE;
            remain_d = '0;
            valid_d  = 1'b0;
            last_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    // A zero-length request is acknowledged but starts nothing.
                    if (burst_valid_i && (burst_len_i != '0)) begin
                        remain_d = burst_len_i;
                        state_d  = RUN;
                    end
                end
                RUN: begin
                    if (load) begin
                        data_d   = fifo_data_i;
                        valid_d  = 1'b1;
                        last_d   = (remain_q == LEN_W'(1));
                        remain_d = remain_q - LEN_W'(1);
                        if (remain_q == LEN_W'(1)) begin
                            state_d = DRAIN;
                        end
                    end else if (handshake) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                    end
                end
                DRAIN: begin
                    if (handshake) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: begin
                    state_d  = IDLE;
                    remain_d = '0;
                    valid_d  = 1'b0;
                    last_d   = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            remain_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            last_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            last_q   <= last_d;
        end
    end

    assign fifo_read_o   = load;
    assign m_valid_o     = valid_q;
    assign m_data_o      = data_q;
    assign m_last_o      = last_q;
    assign remain_o      = remain_q;
    assign busy_o        = (state_q != IDLE);
    assign burst_ready_o = (state_q == IDLE);

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter WIDTH, default 8, word width of the FIFO data and of the output stream.
REQ-002 Parameter LEN_W, default 8, width of burst length and of the remaining-word counter.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst  input  1  reset, synchronous and active-low; asserted when 0.
REQ-005 clear_i  input  1  synchronous soft clear, active-high.
REQ-006 burst_valid_i  input  1  burst request valid.
REQ-007 burst_len_i  input  LEN_W  number of words to drain for the request.
REQ-008 burst_ready_o  output  1  block can accept a burst request.
REQ-009 fifo_empty_i  input  1  empty flag of the attached first-word-fall-through FIFO.
REQ-010 fifo_data_i  input  WIDTH  FIFO head word, valid whenever fifo_empty_i=0.
REQ-011 fifo_read_o  output  1  FIFO pop strobe; the head word is consumed on the same edge.
REQ-012 m_valid_o  output  1  output word valid.
REQ-013 m_data_o  output  WIDTH  output word.
REQ-014 m_last_o  output  1  marks the final word of the burst.
REQ-015 m_ready_i  input  1  downstream accepts the word.
REQ-016 busy_o  output  1  burst in progress (state not IDLE).
REQ-017 remain_o  output  LEN_W  words still to be popped from the FIFO in the current burst.

Function
REQ-018 States: IDLE, RUN, DRAIN; burst_ready_o SHALL be 1 only in IDLE.
REQ-019 IDLE with burst_valid_i=1 and burst_len_i!=0: accept; remain <= burst_len_i; go to RUN.
REQ-020 IDLE with burst_valid_i=1 and burst_len_i=0: handshake completes, no state change, no output.
REQ-021 The output uses one register stage; a handshake occurs when m_valid_o && m_ready_i.
REQ-022 load = (state==RUN) && remain!=0 && !fifo_empty_i && (!m_valid_o || m_ready_i).
- fifo_read_o SHALL equal load, combinationally.
REQ-023 On load:
- m_data_o <= fifo_data_i; m_valid_o <= 1.
- m_last_o <= (remain==1).
- remain <= remain-1.
REQ-024 With no load, a handshake clears m_valid_o and m_last_o.
- Otherwise the register holds: data stable while m_valid_o=1 and m_ready_i=0.
REQ-025 Back-to-back: with m_ready_i held at 1 and the FIFO non-empty, one word SHALL be popped and one delivered per cycle.
- Pop-to-m_valid_o latency is 1 cycle.
REQ-026 An empty FIFO during RUN stalls popping with no error; popping resumes on the first cycle fifo_empty_i=0.
REQ-027 RUN -> DRAIN on the load that makes remain 0.
REQ-028 DRAIN -> IDLE on the handshake of the m_last_o word.
- A new burst SHALL NOT be accepted before the cycle after that handshake.
REQ-029 fifo_read_o SHALL never be 1 while fifo_empty_i=1, in IDLE or DRAIN, or when remain=0.
REQ-030 remain_o SHALL never wrap.
- burst_len_i = 2^LEN_W-1 is legal and SHALL deliver exactly that many words.
REQ-031 clear_i=1 with rst deasserted:
- Next cycle: state IDLE, remain 0, m_valid_o/m_last_o 0.
- Any held word is discarded; fifo_read_o=0 in the clear cycle.
- clear_i takes priority over burst acceptance and load.

Reset
REQ-032 While rst=0 at posedge:
- State IDLE, remain_o=0, m_valid_o=0, m_last_o=0, m_data_o=0.
- busy_o=0, burst_ready_o=1 after the edge.
- fifo_read_o=0 during the reset cycle.
REQ-033 Reset mid-burst SHALL abandon the burst with identical results; no FIFO pop occurs in the reset cycle.

Verification
REQ-034 FIFO holds A,B,C; burst_len=3; m_ready_i=1 -> fifo_read_o high 3 consecutive cycles; m_data_o A,B,C on consecutive cycles; m_last_o only with C; busy_o falls after C is accepted.
REQ-035 burst_len=4; FIFO empty for 5 cycles, then 4 words written -> no pop while empty; 4 words delivered in order; remain_o goes 4,3,2,1,0.
REQ-036 burst_len=2; m_ready_i=0 for 3 cycles -> exactly 1 pop; m_data_o stable; second pop occurs in the cycle m_ready_i rises.
REQ-037 burst_len=0 -> no pop, busy_o stays 0, burst_ready_o stays 1.
REQ-038 clear_i mid-burst (remain=5, word held) -> next cycle m_valid_o=0, remain_o=0, IDLE; a new burst_len=1 then delivers 1 word with m_last_o=1.
REQ-039 rst=0 pulse during RUN -> all outputs at reset values next cycle; FIFO occupancy unchanged by the reset cycle.
